// File: rtl/db9_pkg.sv
// Shared types for the DB9 Mega Drive pad reader.
// State encoding, DB9 pin indices and the button bundle.
package db9_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PH0,
    S_PH1,
    S_PH2,
    S_PH3,
    S_PH4,
    S_PH5,
    S_PH6,
    S_PH7,
    S_RECOV
  } state_t;

  localparam int DB9_UP    = 0;
  localparam int DB9_DOWN  = 1;
  localparam int DB9_LEFT  = 2;
  localparam int DB9_RIGHT = 3;
  localparam int DB9_TL    = 4;
  localparam int DB9_TR    = 5;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic a;
    logic b;
    logic c;
    logic start;
    logic mode;
    logic x;
    logic y;
    logic z;
  } db9_btn_t;

  // An absent pad publishes nothing; a 3-button pad has no X/Y/Z/MODE.
  function automatic db9_btn_t btn_mask(
    input db9_btn_t b,
    input logic     pr,
    input logic     six
  );
    db9_btn_t r;
    r = pr ? b : '0;
    if (!six) begin
      r.mode = 1'b0;
      r.x    = 1'b0;
      r.y    = 1'b0;
      r.z    = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/db9_sync.sv
// 6-bit two-flop synchroniser for the raw DB9 pins.
// Ports: clk, rst_n (async, low), d (raw), q (synchronised); resets to ones.
module db9_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] d,
  output logic [5:0] q
);

  logic [5:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/db9_pad_reader.sv
// Polls a Mega Drive 3/6-button pad through TH and publishes decoded buttons.
// Ports: CLK, RESET_N, CE, POLL, J3BUT, DB9_IN -> DB9_TH, P_*, PRESENT, SIX_BTN, VALID, BUSY.
module db9_pad_reader
  import db9_pkg::*;
#(
  parameter int SETTLE  = 8,
  parameter int RECOVER = 2048
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic       POLL,
  input  logic       J3BUT,
  input  logic [5:0] DB9_IN,
  output logic       DB9_TH,
  output logic       P_UP,
  output logic       P_DOWN,
  output logic       P_LEFT,
  output logic       P_RIGHT,
  output logic       P_A,
  output logic       P_B,
  output logic       P_C,
  output logic       P_START,
  output logic       P_MODE,
  output logic       P_X,
  output logic       P_Y,
  output logic       P_Z,
  output logic       PRESENT,
  output logic       SIX_BTN,
  output logic       VALID,
  output logic       BUSY
);

  localparam int CMAX = (SETTLE > RECOVER) ? SETTLE : RECOVER;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(RECOVER - 1);

  state_t          state;
  state_t          nstate;
  logic [CW-1:0]   cnt;
  logic [5:0]      pin;
  logic            pend;
  logic            j3;
  db9_btn_t        sh;
  db9_btn_t        sh_n;
  db9_btn_t        btn;
  logic            pr_sh;
  logic            pr_n;
  logic            six_sh;
  logic            six_n;
  logic            ph_last;
  logic            rec_last;
  logic            start;
  logic            pub;

  db9_sync u_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (DB9_IN),
    .q     (pin)
  );

  assign ph_last  = CE && (cnt == SET_LAST);
  assign rec_last = CE && (cnt == REC_LAST);
  assign start    = (state == S_IDLE) && (POLL || pend);
  assign pub      = (nstate == S_RECOV) && (state != S_RECOV);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:  if (POLL || pend) nstate = S_PH0;
      S_PH0:   if (ph_last) nstate = S_PH1;
      S_PH1:   if (ph_last) nstate = j3 ? S_RECOV : S_PH2;
      S_PH2:   if (ph_last) nstate = S_PH3;
      S_PH3:   if (ph_last) nstate = S_PH4;
      S_PH4:   if (ph_last) nstate = S_PH5;
      S_PH5:   if (ph_last) nstate = S_PH6;
      S_PH6:   if (ph_last) nstate = S_PH7;
      S_PH7:   if (ph_last) nstate = S_RECOV;
      S_RECOV: if (rec_last) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    DB9_TH = 1'b1;
    BUSY   = 1'b1;
    unique case (state)
      S_IDLE:                     BUSY   = 1'b0;
      S_PH1, S_PH3, S_PH5, S_PH7: DB9_TH = 1'b0;
      default: ;
    endcase
  end

  // Counter restarts on every state change, so a phase never wraps.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                       cnt <= '0;
    else if (nstate != state)           cnt <= '0;
    else if (CE && state != S_IDLE)     cnt <= cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)              pend <= 1'b0;
    else if (state == S_IDLE)  pend <= 1'b0;
    else if (POLL)             pend <= 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)   j3 <= 1'b0;
    else if (start) j3 <= J3BUT;
  end

  // Next shadow contents; the publish path uses these directly so a
  // capture on the RECOV-entry tick is included in the same update.
  always_comb begin
    sh_n  = sh;
    pr_n  = pr_sh;
    six_n = six_sh;
    if (start) begin
      sh_n  = '0;
      pr_n  = 1'b0;
      six_n = 1'b0;
    end else if (ph_last) begin
      unique case (state)
        S_PH0: begin
          sh_n.up    = ~pin[DB9_UP];
          sh_n.down  = ~pin[DB9_DOWN];
          sh_n.left  = ~pin[DB9_LEFT];
          sh_n.right = ~pin[DB9_RIGHT];
          sh_n.b     = ~pin[DB9_TL];
          sh_n.c     = ~pin[DB9_TR];
        end
        S_PH1: begin
          sh_n.a     = ~pin[DB9_TL];
          sh_n.start = ~pin[DB9_TR];
          pr_n       = ~pin[DB9_LEFT] & ~pin[DB9_RIGHT];
        end
        S_PH5: six_n = (pin[3:0] == 4'b0000);
        S_PH6: begin
          if (six_sh) begin
            sh_n.z    = ~pin[DB9_UP];
            sh_n.y    = ~pin[DB9_DOWN];
            sh_n.x    = ~pin[DB9_LEFT];
            sh_n.mode = ~pin[DB9_RIGHT];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sh     <= '0;
      pr_sh  <= 1'b0;
      six_sh <= 1'b0;
    end else begin
      sh     <= sh_n;
      pr_sh  <= pr_n;
      six_sh <= six_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn     <= '0;
      PRESENT <= 1'b0;
      SIX_BTN <= 1'b0;
      VALID   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (pub) begin
        btn     <= btn_mask(sh_n, pr_n, six_n);
        PRESENT <= pr_n;
        SIX_BTN <= pr_n & six_n;
        VALID   <= 1'b1;
      end
    end
  end

  assign P_UP    = btn.up;
  assign P_DOWN  = btn.down;
  assign P_LEFT  = btn.left;
  assign P_RIGHT = btn.right;
  assign P_A     = btn.a;
  assign P_B     = btn.b;
  assign P_C     = btn.c;
  assign P_START = btn.start;
  assign P_MODE  = btn.mode;
  assign P_X     = btn.x;
  assign P_Y     = btn.y;
  assign P_Z     = btn.z;

endmodule

// File: tb/tb_db9_pad_reader.sv
// Directed bench for db9_pad_reader with a behavioural Mega Drive pad.
// Pad model tracks TH falling edges and resets after TH stays high.
module tb_db9_pad_reader;

  localparam int SETTLE  = 4;
  localparam int RECOVER = 16;

  localparam logic [11:0] K_UP    = 12'h800;
  localparam logic [11:0] K_RIGHT = 12'h100;
  localparam logic [11:0] K_A     = 12'h080;
  localparam logic [11:0] K_C     = 12'h020;
  localparam logic [11:0] K_START = 12'h010;
  localparam logic [11:0] K_MODE  = 12'h008;
  localparam logic [11:0] K_X     = 12'h004;
  localparam logic [11:0] K_Z     = 12'h001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce = 1'b0;
  logic       poll;
  logic       j3but;
  logic [5:0] db9_in;
  logic       th;
  logic       p_up, p_down, p_left, p_right, p_a, p_b, p_c, p_start;
  logic       p_mode, p_x, p_y, p_z;
  logic       present, six_btn, valid, busy;
  logic [11:0] pbus;

  int nvec = 0;
  int nerr = 0;

  logic        pad_on;
  logic        six_pad;
  logic [11:0] held;
  logic [5:0]  pad_raw;
  logic [3:0]  pk = '0;
  int          hi_cnt = 0;
  logic        th_q = 1'b1;
  int          falls_tot = 0;
  int          valid_tot = 0;

  db9_pad_reader #(.SETTLE(SETTLE), .RECOVER(RECOVER)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .CE      (ce),
    .POLL    (poll),
    .J3BUT   (j3but),
    .DB9_IN  (db9_in),
    .DB9_TH  (th),
    .P_UP    (p_up),
    .P_DOWN  (p_down),
    .P_LEFT  (p_left),
    .P_RIGHT (p_right),
    .P_A     (p_a),
    .P_B     (p_b),
    .P_C     (p_c),
    .P_START (p_start),
    .P_MODE  (p_mode),
    .P_X     (p_x),
    .P_Y     (p_y),
    .P_Z     (p_z),
    .PRESENT (present),
    .SIX_BTN (six_btn),
    .VALID   (valid),
    .BUSY    (busy)
  );

  assign pbus = {p_up, p_down, p_left, p_right, p_a, p_b, p_c,
                 p_start, p_mode, p_x, p_y, p_z};

  always #5 clk = ~clk;
  always @(negedge clk) ce = ~ce;

  always @(posedge clk) begin
    th_q <= th;
    if (th_q && !th) begin
      falls_tot <= falls_tot + 1;
      pk        <= pk + 1'b1;
    end
    hi_cnt <= th ? hi_cnt + 1 : 0;
    if (th && hi_cnt > 20) pk <= '0;
    if (valid) valid_tot <= valid_tot + 1;
  end

  // held order: UP DOWN LEFT RIGHT A B C START MODE X Y Z (bit 11..0)
  always_comb begin
    db9_in = pad_raw;
    if (pad_on) begin
      if (th) begin
        if (six_pad && pk == 4'd3)
          db9_in = ~{held[5], held[6], held[3], held[2], held[1], held[0]};
        else
          db9_in = ~{held[5], held[6], held[8], held[9], held[10], held[11]};
      end else begin
        if (six_pad && pk == 4'd3)
          db9_in = ~{held[4], held[7], 4'b1111};
        else
          db9_in = ~{held[4], held[7], 2'b11, held[10], held[11]};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(posedge clk); #1;
      if (!busy) ok = 1;
    end
    if (!ok) chk({tag, "_idle_timeout"}, 0, 1);
  endtask

  task automatic run_poll(input string tag, input logic [11:0] eb,
                          input bit ep, input bit es, input int eticks,
                          input int efalls, input bit flip);
    int  f0;
    int  ticks;
    bit  got;
    f0    = falls_tot;
    ticks = 0;
    got   = 0;
    @(negedge clk) poll = 1'b1;
    @(negedge clk) poll = 1'b0;
    for (int n = 0; n < 4000 && !got; n++) begin
      @(posedge clk);
      if (ce) ticks++;
      #1;
      if (valid) got = 1;
      if (n == 3 && flip) j3but = ~j3but;
    end
    chk({tag, "_valid"}, 32'(got), 1);
    chk({tag, "_ticks"}, ticks, eticks);
    chk({tag, "_bus"}, 32'(pbus), 32'(eb));
    chk({tag, "_present"}, 32'(present), 32'(ep));
    chk({tag, "_six"}, 32'(six_btn), 32'(es));
    @(posedge clk); #1;
    chk({tag, "_valid_pulse"}, 32'(valid), 0);
    chk({tag, "_busy_recov"}, 32'(busy), 1);
    wait_idle(tag);
    chk({tag, "_falls"}, falls_tot - f0, efalls);
  endtask

  initial begin
    int  f0;
    int  v0;
    int  bcnt;
    bit  ok;
    rst_n   = 1'b0;
    poll    = 1'b0;
    j3but   = 1'b0;
    pad_on  = 1'b0;
    six_pad = 1'b0;
    held    = '0;
    pad_raw = 6'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) pad_raw = 6'($urandom);
    end
    chk("rst_th", 32'(th), 1);
    chk("rst_bus", 32'(pbus), 0);
    chk("rst_present", 32'(present), 0);
    chk("rst_six", 32'(six_btn), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    @(negedge clk) rst_n = 1'b1;
    pad_on = 1'b1;
    repeat (40) @(negedge clk);

    // 3-button pad, forced 3-button protocol
    six_pad = 1'b0;
    held    = K_A | K_RIGHT;
    j3but   = 1'b1;
    run_poll("p3_j3", K_A | K_RIGHT, 1, 0, 2 * SETTLE, 1, 0);

    // 3-button pad, full sequence: no 6-button ID seen
    j3but = 1'b0;
    run_poll("p3_full", K_A | K_RIGHT, 1, 0, 8 * SETTLE, 4, 0);

    // 6-button pad; J3BUT raised mid-PH0 must be ignored
    six_pad = 1'b1;
    held    = K_X | K_MODE | K_START;
    j3but   = 1'b0;
    run_poll("p6", K_X | K_MODE | K_START, 1, 1, 8 * SETTLE, 4, 1);
    j3but = 1'b0;

    // reset in PH3
    f0 = falls_tot;
    @(negedge clk) poll = 1'b1;
    @(negedge clk) poll = 1'b0;
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(posedge clk); #1;
      if (falls_tot - f0 == 2 && !th) ok = 1;
    end
    chk("ph3_reach", 32'(ok), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ph3rst_th", 32'(th), 1);
    chk("ph3rst_busy", 32'(busy), 0);
    chk("ph3rst_bus", 32'(pbus), 0);
    chk("ph3rst_present", 32'(present), 0);
    chk("ph3rst_six", 32'(six_btn), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // forced 3-button with 6-button pad: Z hidden
    six_pad = 1'b1;
    held    = K_Z | K_C;
    j3but   = 1'b1;
    run_poll("p6_j3", K_C, 1, 0, 2 * SETTLE, 1, 0);
    j3but = 1'b0;

    // no pad
    pad_on  = 1'b0;
    pad_raw = 6'b111111;
    run_poll("nopad", 12'h000, 0, 0, 8 * SETTLE, 4, 0);
    pad_raw = 6'b001111;
    run_poll("nopad_tltr", 12'h000, 0, 0, 8 * SETTLE, 4, 0);
    pad_on = 1'b1;

    // requests while busy
    six_pad = 1'b1;
    held    = K_UP;
    v0 = valid_tot;
    f0 = falls_tot;
    @(negedge clk) poll = 1'b1;
    @(negedge clk) poll = 1'b0;
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(posedge clk); #1;
      if (falls_tot - f0 == 2 && th) ok = 1;
    end
    chk("pend_ph4", 32'(ok), 1);
    repeat (3) begin
      @(negedge clk) poll = 1'b1;
      @(negedge clk) poll = 1'b0;
    end
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(posedge clk); #1;
      if (valid) ok = 1;
    end
    chk("pend_valid1", 32'(ok), 1);
    chk("pend_bus1", 32'(pbus), 32'(K_UP));
    repeat (4) @(negedge clk);
    poll = 1'b1;
    @(negedge clk) poll = 1'b0;
    wait_idle("pend1");
    @(posedge clk); #1;
    chk("pend_restart", 32'(busy), 1);
    wait_idle("pend2");
    bcnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
    end
    chk("pend_no_third", bcnt, 0);
    chk("pend_valid_cnt", valid_tot - v0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
